// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | alu_pkg : shared widths and op codes for the 16-bit ALU and its arbiter
// | Revision: 1.0
// +----------------------------------------------------------------------------
package alu_pkg;

  localparam int DATA_W = 16;
  localparam int OP_W   = 4;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_NOT   = 4'b0100;
  localparam logic [3:0] ALU_SRA   = 4'b0101;
  localparam logic [3:0] ALU_SLL   = 4'b0110;
  localparam logic [3:0] ALU_SLT   = 4'b0111;
  localparam logic [3:0] ALU_ZERO  = 4'b1000;
  localparam logic [3:0] ALU_PASSA = 4'b1001;
  localparam logic [3:0] ALU_LNOT  = 4'b1010;
  localparam logic [3:0] ALU_NEQ   = 4'b1011;
  localparam logic [3:0] ALU_PASSB = 4'b1100;

  localparam logic [3:0] OP_MAX = ALU_PASSB;

endpackage
`default_nettype wire

// File: rtl/alu_share_arbiter_rr_arb2.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | rr_arb2 : two-input round-robin grant, pointer moves only on accept
// | Config : ALU_ARB_FIXED_PRIO_EN selects fixed priority (input 0 wins)
// | Revision: 1.0
// +----------------------------------------------------------------------------
module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic valid0,
  input  logic valid1,
  input  logic accept,
  input  logic accept_id,
  output logic grant0,
  output logic grant1
);

`ifdef ALU_ARB_FIXED_PRIO_EN
  logic unused_inputs;
  assign unused_inputs = &{1'b0, clk, rst, accept, accept_id};

  assign grant0 = valid0;
  assign grant1 = valid1 & ~valid0;
`else
  logic rr_ptr;

  assign grant0 = valid0 & (~valid1 | ~rr_ptr);
  assign grant1 = valid1 & (~valid0 |  rr_ptr);

  // The winner just served drops to lowest priority for the next contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= 1'b0;
    end else if (accept) begin
      rr_ptr <= ~accept_id;
    end
  end
`endif

endmodule
`default_nettype wire

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | alu_share_arbiter : shares one combinational ALU between EX and branch unit
// | Config : ALU_ARB_FIXED_PRIO_EN (fixed priority instead of round-robin)
// | Revision: 1.0
// +----------------------------------------------------------------------------
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int               DATA_W = 16,
  parameter int               OP_W   = 4,
  parameter logic [OP_W-1:0]  OP_MAX = 4'b1100
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_first,
  input  logic [DATA_W-1:0] req0_second,
  input  logic [OP_W-1:0]   req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_first,
  input  logic [DATA_W-1:0] req1_second,
  input  logic [OP_W-1:0]   req1_op,
  output logic [DATA_W-1:0] alu_first,
  output logic [DATA_W-1:0] alu_second,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_id,
  output logic [DATA_W-1:0] resp_result,
  output logic              resp_zero,
  output logic              resp_err
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0] r_state;
  logic       w_grant0;
  logic       w_grant1;
  logic       w_out_free;
  logic       w_accept;
  logic       w_illegal;

  rr_arb2 u_arb (
    .clk       (CLK),
    .rst       (RST),
    .valid0    (req0_valid),
    .valid1    (req1_valid),
    .accept    (w_accept),
    .accept_id (w_grant1),
    .grant0    (w_grant0),
    .grant1    (w_grant1)
  );

  assign resp_valid = (r_state == ST_FULL);
  assign w_out_free = ~resp_valid | resp_ready;
  assign req0_ready = w_grant0 & w_out_free;
  assign req1_ready = w_grant1 & w_out_free;
  assign w_accept   = req0_ready | req1_ready;

  always_comb begin
    alu_first  = '0;
    alu_second = '0;
    alu_op     = OP_W'(ALU_ZERO);
    if (w_grant0) begin
      alu_first  = req0_first;
      alu_second = req0_second;
      alu_op     = req0_op;
    end else if (w_grant1) begin
      alu_first  = req1_first;
      alu_second = req1_second;
      alu_op     = req1_op;
    end
  end

  assign w_illegal = (alu_op > OP_MAX);

  // Illegal ops are still consumed so the requester never stalls on them.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= ST_EMPTY;
      resp_id     <= 1'b0;
      resp_result <= '0;
      resp_zero   <= 1'b0;
      resp_err    <= 1'b0;
    end else if (w_accept) begin
      r_state     <= ST_FULL;
      resp_id     <= w_grant1;
      resp_result <= w_illegal ? '0 : alu_result;
      resp_zero   <= w_illegal | alu_zero;
      resp_err    <= w_illegal;
    end else if (resp_ready) begin
      r_state     <= ST_EMPTY;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | tb_alu_share_arbiter : directed self-checking bench with a behavioural ALU
// | Revision: 1.0
// +----------------------------------------------------------------------------
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [15:0] req0_first, req0_second, req1_first, req1_second;
  logic [3:0]  req0_op, req1_op;
  logic [15:0] alu_first, alu_second, alu_result;
  logic [3:0]  alu_op;
  logic        alu_zero;
  logic        resp_valid, resp_ready, resp_id, resp_zero, resp_err;
  logic [15:0] resp_result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_share_arbiter dut (
    .CLK(clk), .RST(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_first(req0_first), .req0_second(req0_second), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_first(req1_first), .req1_second(req1_second), .req1_op(req1_op),
    .alu_first(alu_first), .alu_second(alu_second), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .resp_zero(resp_zero), .resp_err(resp_err)
  );

  // External ALU stand-in; illegal codes return junk that must be masked.
  always_comb begin
    alu_result = 16'hDEAD;
    case (alu_op)
      4'b0000: alu_result = alu_first + alu_second;
      4'b0001: alu_result = alu_first - alu_second;
      4'b1000: alu_result = 16'h0000;
      4'b1001: alu_result = alu_first;
      4'b1100: alu_result = alu_second;
      default: alu_result = 16'hDEAD;
    endcase
    alu_zero = (alu_result == 16'h0000);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_resp(input string tag, input logic id, input logic [15:0] res,
                          input logic zero, input logic err);
    chk({tag, "_valid"},  32'(resp_valid),  32'd1);
    chk({tag, "_id"},     32'(resp_id),     32'(id));
    chk({tag, "_result"}, 32'(resp_result), 32'(res));
    chk({tag, "_zero"},   32'(resp_zero),   32'(zero));
    chk({tag, "_err"},    32'(resp_err),    32'(err));
  endtask

  logic exp_g [4];

  initial begin
    rst = 1'b1;
    req0_valid = 0; req0_first = 0; req0_second = 0; req0_op = 0;
    req1_valid = 0; req1_first = 0; req1_second = 0; req1_op = 0;
    resp_ready = 0;
    tick(); tick();
    chk("rst_valid",  32'(resp_valid),  32'd0);
    chk("rst_id",     32'(resp_id),     32'd0);
    chk("rst_result", 32'(resp_result), 32'd0);
    chk("rst_zero",   32'(resp_zero),   32'd0);
    chk("rst_err",    32'(resp_err),    32'd0);
    chk("idle_op",    32'(alu_op),      32'h8);
    chk("idle_rdy0",  32'(req0_ready),  32'd0);
    rst = 1'b0;
    tick();

    // 1: single ADD from requester 0
    req0_valid = 1; req0_first = 16'h0003; req0_second = 16'h0004; req0_op = 4'b0000;
    resp_ready = 1;
    #1;
    chk("t1_rdy0",  32'(req0_ready), 32'd1);
    chk("t1_rdy1",  32'(req1_ready), 32'd0);
    chk("t1_alu_a", 32'(alu_first),  32'h3);
    tick();
    req0_valid = 0;
    #1;
    chk_resp("t1", 1'b0, 16'h0007, 1'b0, 1'b0);

    // 2: contention; pointer is 1 after the requester 0 accept above
    req0_valid = 1; req0_first = 16'd5; req0_second = 16'd5; req0_op = 4'b0001;
    req1_valid = 1; req1_first = 16'd0; req1_second = 16'h1234; req1_op = 4'b1100;
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_g = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    exp_g = '{1'b1, 1'b0, 1'b1, 1'b0};
`endif
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_rdy0", 32'(req0_ready), 32'(!exp_g[i]));
      chk("t2_rdy1", 32'(req1_ready), 32'(exp_g[i]));
      tick();
      chk_resp("t2", exp_g[i], exp_g[i] ? 16'h1234 : 16'h0000, !exp_g[i], 1'b0);
    end
    req0_valid = 0; req1_valid = 0;
    tick();
    chk("t2_drain", 32'(resp_valid), 32'd0);

    // 3: backpressure
    req0_valid = 1; req0_first = 16'h0010; req0_second = 16'h0020; req0_op = 4'b0000;
    resp_ready = 0;
    #1;
    chk("t3_rdy0", 32'(req0_ready), 32'd1);
    tick();
    req0_first = 16'h0001; req0_second = 16'h0001;
    req1_valid = 1; req1_first = 16'd0; req1_second = 16'h0055; req1_op = 4'b1100;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t3_hold_rdy0", 32'(req0_ready), 32'd0);
      chk("t3_hold_rdy1", 32'(req1_ready), 32'd0);
      chk_resp("t3_hold", 1'b0, 16'h0030, 1'b0, 1'b0);
      tick();
    end
    resp_ready = 1;
    #1;
`ifdef ALU_ARB_FIXED_PRIO_EN
    chk("t3_rdy0", 32'(req0_ready), 32'd1);
    tick();
    req0_valid = 0;
    chk_resp("t3_new", 1'b0, 16'h0002, 1'b0, 1'b0);
    tick();
    req1_valid = 0;
    chk_resp("t3_next", 1'b1, 16'h0055, 1'b0, 1'b0);
`else
    chk("t3_rdy1", 32'(req1_ready), 32'd1);
    chk("t3_rdy0", 32'(req0_ready), 32'd0);
    tick();
    req1_valid = 0;
    chk_resp("t3_new", 1'b1, 16'h0055, 1'b0, 1'b0);
    tick();
    req0_valid = 0;
    chk_resp("t3_next", 1'b0, 16'h0002, 1'b0, 1'b0);
`endif
    tick();

    // 4: illegal op is accepted and flagged
    req1_valid = 1; req1_first = 16'hFFFF; req1_second = 16'h0001; req1_op = 4'b1110;
    #1;
    chk("t4_rdy1", 32'(req1_ready), 32'd1);
    tick();
    req1_valid = 0;
    chk_resp("t4", 1'b1, 16'h0000, 1'b1, 1'b1);
    req0_valid = 1; req0_first = 16'h0002; req0_second = 16'h0002; req0_op = 4'b0000;
    tick();
    chk_resp("t4_clr", 1'b0, 16'h0004, 1'b0, 1'b0);

    // 5: reset while a response is held
    resp_ready = 0;
    req1_valid = 1; req1_first = 16'd0; req1_second = 16'h00AA; req1_op = 4'b1100;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_flush", 32'(resp_valid), 32'd0);
    #1;
    chk("t5_rdy0", 32'(req0_ready), 32'd1);
    chk("t5_rdy1", 32'(req1_ready), 32'd0);
    resp_ready = 1;
    tick();
    req0_valid = 0;
    chk_resp("t5", 1'b0, 16'h0004, 1'b0, 1'b0);

    // 6: lone requester 1 does not starve requester 0 afterwards
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t6_rdy1", 32'(req1_ready), 32'd1);
      tick();
      chk_resp("t6", 1'b1, 16'h00AA, 1'b0, 1'b0);
    end
    req0_valid = 1; req0_first = 16'h0100; req0_second = 16'h0001; req0_op = 4'b0000;
    #1;
    chk("t6_rdy0", 32'(req0_ready), 32'd1);
    chk("t6_rdy1_lo", 32'(req1_ready), 32'd0);
    tick();
    req0_valid = 0; req1_valid = 0;
    chk_resp("t6_win", 1'b0, 16'h0101, 1'b0, 1'b0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
